// File: rtl/csync_gen.sv
// Composite-sync regenerator: deglitches raw HSYNC/VSYNC, measures the line period
// and emits a clean active-low csync with fixed-width (or serrated) pulses.
module csync_gen #(
    parameter int FILTER_LEN = 8,
    parameter int HPULSE     = 479,
    parameter int PERIOD_MIN = 5000,
    parameter int PERIOD_MAX = 8000,
    parameter int PERIOD_W   = 14
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                locked,
    input  logic                hsync_in,
    input  logic                vsync_in,
    output logic                csync_out,
    output logic [PERIOD_W-1:0] line_period,
    output logic                period_valid,
    output logic                vsync_active
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int TMR_W  = $clog2(HPULSE + 1);
    localparam logic [PERIOD_W-1:0] CNT_SAT   = PERIOD_W'(PERIOD_MAX + 1);
    localparam logic [PERIOD_W-1:0] CNT_MIN   = PERIOD_W'(PERIOD_MIN);
    localparam logic [PERIOD_W-1:0] CNT_MAX   = PERIOD_W'(PERIOD_MAX);
    localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [TMR_W-1:0]    TMR_LOAD  = TMR_W'(HPULSE);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LINE, VLINE} state_t;

    logic [1:0] raw_in;
    logic [1:0] filt;
    assign raw_in = {vsync_in, hsync_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filter
            logic              sync1_reg;
            logic              sync2_reg;
            logic              level_reg;
            logic [FCNT_W-1:0] stable_cnt_reg;

            // The level flips on the FILTER_LEN-th consecutive opposite sample.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    sync1_reg      <= 1'b1;
                    sync2_reg      <= 1'b1;
                    level_reg      <= 1'b1;
                    stable_cnt_reg <= '0;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == level_reg) begin
                        stable_cnt_reg <= '0;
                    end else if (stable_cnt_reg == FCNT_LAST) begin
                        level_reg      <= sync2_reg;
                        stable_cnt_reg <= '0;
                    end else begin
                        stable_cnt_reg <= stable_cnt_reg + 1'b1;
                    end
                end
            end

            assign filt[gi] = level_reg;
        end
    endgenerate

    logic                hfilt;
    logic                vfilt;
    logic                hprev_reg;
    logic                hfall;
    state_t              state_reg, state_next;
    logic [PERIOD_W-1:0] count_reg, count_next;
    logic [TMR_W-1:0]    timer_reg, timer_next;
    logic [PERIOD_W-1:0] period_reg, period_next;
    logic                valid_reg, valid_next;
    logic                csync_reg, csync_next;
    logic                in_line;
    logic                accept;
    logic                timeout;
    logic                pulse_next;

    assign hfilt = filt[0];
    assign vfilt = filt[1];
    assign hfall = hprev_reg & ~hfilt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            timer_reg  <= '0;
            period_reg <= '0;
            valid_reg  <= 1'b0;
            csync_reg  <= 1'b1;
            hprev_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            timer_reg  <= timer_next;
            period_reg <= period_next;
            valid_reg  <= valid_next;
            csync_reg  <= csync_next;
            hprev_reg  <= hfilt;
        end
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        timer_next  = timer_reg;
        period_next = period_reg;
        valid_next  = valid_reg;
        csync_next  = 1'b1;

        in_line = (state_reg == LINE) || (state_reg == VLINE);
        accept  = hfall && ((state_reg == ACQUIRE) || (in_line && (count_reg >= CNT_MIN)));
        timeout = in_line && (count_reg > CNT_MAX);

        if (!locked) begin
            state_next = IDLE;
            count_next = '0;
            timer_next = '0;
            valid_next = 1'b0;
        end else if (state_reg == IDLE) begin
            state_next = ACQUIRE;
            count_next = '0;
            timer_next = '0;
        end else begin
            count_next = (count_reg >= CNT_SAT) ? CNT_SAT : count_reg + 1'b1;
            if (timer_reg != '0) begin
                timer_next = timer_reg - 1'b1;
            end
            if (accept) begin
                // Restarting at 1 makes the count equal the clocks elapsed since this edge.
                count_next = PERIOD_W'(1);
                timer_next = TMR_LOAD;
                state_next = vfilt ? LINE : VLINE;
                if (in_line) begin
                    period_next = count_reg;
                    valid_next  = 1'b1;
                end
            end else if (timeout) begin
                state_next = ACQUIRE;
                valid_next = 1'b0;
                timer_next = '0;
            end
        end

        // Output follows the state being entered so the pulse starts on the accepting edge.
        pulse_next = (timer_next != '0);
        case (state_next)
            LINE:    csync_next = ~pulse_next;
            VLINE:   csync_next = pulse_next;
            default: csync_next = 1'b1;
        endcase
    end

    assign csync_out    = csync_reg;
    assign line_period  = period_reg;
    assign period_valid = valid_reg;
    assign vsync_active = (state_reg == VLINE);

endmodule

// File: tb/tb_csync_gen.sv
// Bench for csync_gen: line-by-line stimulus with randomized widths and periods, checked
// every clock against an event-level model of the sync regeneration rules.
module tb_csync_gen;

    localparam int FILTER_LEN = 8;
    localparam int HPULSE     = 479;
    localparam int PERIOD_MIN = 5000;
    localparam int PERIOD_MAX = 8000;
    localparam int PERIOD_W   = 14;
    localparam int NMAX       = 100000;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                locked = 1'b0;
    logic                hsync_in = 1'b1;
    logic                vsync_in = 1'b1;
    logic                csync_out;
    logic [PERIOD_W-1:0] line_period;
    logic                period_valid;
    logic                vsync_active;

    csync_gen #(
        .FILTER_LEN(FILTER_LEN),
        .HPULSE    (HPULSE),
        .PERIOD_MIN(PERIOD_MIN),
        .PERIOD_MAX(PERIOD_MAX),
        .PERIOD_W  (PERIOD_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .locked      (locked),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .csync_out   (csync_out),
        .line_period (line_period),
        .period_valid(period_valid),
        .vsync_active(vsync_active)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    int line_no = 0;

    // Raw levels driven after each edge, and the filtered levels those imply.
    bit raw_h [NMAX];
    bit raw_v [NMAX];
    bit fh    [NMAX];
    bit fv    [NMAX];

    // Model: locked-and-running, tracking lines, vsync line, last accepted edge, pulse end edge.
    bit m_active, m_tracking, m_vline, m_pvalid;
    int m_last, m_pend, m_period;

    int ev_g7 = -1, ev_g8 = -1, ev_v_at = -1, ev_lock_at = -1, ev_rst_at = -1;
    bit ev_v_val = 1'b1;
    bit v_lvl = 1'b1;
    bit lock_lvl = 1'b0;

    // A filtered level follows the raw input once FILTER_LEN consecutive synchronized samples agree.
    function automatic bit filtered(input bit prev, input int k, input bit is_h);
        bit r0;
        if (k < FILTER_LEN + 2) return prev;
        r0 = is_h ? raw_h[k-3] : raw_v[k-3];
        for (int j = k - 2 - FILTER_LEN; j <= k - 3; j++) begin
            if ((is_h ? raw_h[j] : raw_v[j]) != r0) return prev;
        end
        return r0;
    endfunction

    task automatic model_edge(input bit lk, input bit r);
        bit hf;
        int el;
        if (r) begin
            fh[n] = 1'b1;
            fv[n] = 1'b1;
        end else begin
            fh[n] = filtered(fh[n-1], n, 1'b1);
            fv[n] = filtered(fv[n-1], n, 1'b0);
        end
        hf = (n >= 2) && fh[n-2] && !fh[n-1];
        el = n - m_last;
        if (r) begin
            m_active = 0; m_tracking = 0; m_vline = 0; m_pvalid = 0;
            m_period = 0; m_pend = 0; m_last = 0;
        end else if (!lk) begin
            m_active = 0; m_tracking = 0; m_vline = 0; m_pvalid = 0; m_pend = n;
        end else if (!m_active) begin
            m_active = 1;
        end else if (hf && (!m_tracking || el >= PERIOD_MIN)) begin
            if (m_tracking) begin
                m_period = el;
                m_pvalid = 1;
            end
            m_tracking = 1;
            m_vline = !fv[n-1];
            m_last = n;
            m_pend = n + HPULSE;
        end else if (m_tracking && el > PERIOD_MAX) begin
            m_tracking = 0; m_pvalid = 0; m_pend = n;
        end
    endtask

    task automatic cyc(input bit h, input bit v, input bit lk, input bit r);
        logic [16:0] got, want;
        bit pulse, e_cs;
        hsync_in = h;
        vsync_in = v;
        locked   = lk;
        reset_n  = !r;
        raw_h[n] = h;
        raw_v[n] = v;
        @(posedge clock);
        n++;
        model_edge(lk, r);
        #1;
        pulse = (n < m_pend);
        e_cs  = !m_tracking ? 1'b1 : (m_vline ? pulse : !pulse);
        got   = {csync_out, vsync_active, period_valid, line_period};
        want  = {e_cs, m_tracking && m_vline, m_pvalid, PERIOD_W'(m_period)};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL edge%0d cs/va/pv/lp got %b/%b/%b/%0d want %b/%b/%b/%0d", n,
                   got[16], got[15], got[14], got[13:0], want[16], want[15], want[14], want[13:0]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // One line: hsync low for `low` clocks, then high for the rest of `period`.
    task automatic line(input int low, input int period);
        bit h, lk, r;
        for (int i = 0; i < period; i++) begin
            h = (i >= low);
            if (ev_g7 >= 0 && i >= ev_g7 && i < ev_g7 + 7) h = 1'b0;
            if (ev_g8 >= 0 && i >= ev_g8 && i < ev_g8 + 8) h = 1'b0;
            if (i == ev_v_at) v_lvl = ev_v_val;
            lk = lock_lvl;
            if (ev_lock_at >= 0 && i >= ev_lock_at && i < ev_lock_at + 50) lk = 1'b0;
            r = (ev_rst_at >= 0 && i >= ev_rst_at && i < ev_rst_at + 4);
            cyc(h, v_lvl, lk, r);
        end
        line_no++;
        $display("line %0d: low=%0d period=%0d csync=%b vact=%b pv=%b lp=%0d", line_no, low,
                 period, csync_out, vsync_active, period_valid, line_period);
        ev_g7 = -1; ev_g8 = -1; ev_v_at = -1; ev_lock_at = -1; ev_rst_at = -1;
    endtask

    initial begin
        int p5, p6, p7;
        for (int i = 0; i < NMAX; i++) begin
            raw_h[i] = 1'b1; raw_v[i] = 1'b1; fh[i] = 1'b1; fv[i] = 1'b1;
        end
        m_active = 0; m_tracking = 0; m_vline = 0; m_pvalid = 0;
        m_last = 0; m_pend = 0; m_period = 0;

        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b1);

        // Unlocked: hsync toggles but nothing comes out.
        line(200, 3000);
        line(100, 2000);
        chk("unlk_cs", 32'(csync_out), 32'd1);
        chk("unlk_pv", 32'(period_valid), 32'd0);
        chk("unlk_lp", 32'(line_period), 32'd0);

        // Normal lines, the second carrying a 7-clock glitch and a too-early 8-clock fall.
        lock_lvl = 1'b1;
        line(200, 6477);
        ev_g7 = 1500; ev_g8 = 3000;
        line(200, 6477);
        chk("norm_lp", 32'(line_period), 32'd6477);
        chk("norm_pv", 32'(period_valid), 32'd1);
        chk("norm_va", 32'(vsync_active), 32'd0);

        // Minimum-width low at minimum period, then the maximum period with vsync dropping.
        line(8, PERIOD_MIN);
        ev_v_at = 4000; ev_v_val = 1'b0;
        line($urandom_range(8, 700), PERIOD_MAX);
        chk("min_lp", 32'(line_period), 32'(PERIOD_MIN));

        // Three serrated lines; vsync returns high during the third.
        p5 = PERIOD_MIN + $urandom_range(0, 100);
        line($urandom_range(8, 700), p5);
        chk("max_lp", 32'(line_period), 32'(PERIOD_MAX));
        chk("vline_va", 32'(vsync_active), 32'd1);
        chk("vline_cs", 32'(csync_out), 32'd0);
        p6 = PERIOD_MIN + $urandom_range(0, 100);
        line($urandom_range(8, 700), p6);
        chk("vline_lp", 32'(line_period), 32'(p5));
        ev_v_at = 2000; ev_v_val = 1'b1;
        p7 = PERIOD_MIN + $urandom_range(0, 100);
        line($urandom_range(8, 700), p7);

        // Normal line that then times out.
        line(200, 8200);
        chk("tmo_pv", 32'(period_valid), 32'd0);
        chk("tmo_cs", 32'(csync_out), 32'd1);
        chk("tmo_va", 32'(vsync_active), 32'd0);
        chk("tmo_lp", 32'(line_period), 32'(p7));

        // Reacquire, then lose lock 100 clocks into a pulse.
        line($urandom_range(8, 700), PERIOD_MIN);
        ev_lock_at = 110;
        line(200, PERIOD_MIN);
        chk("lock_pv", 32'(period_valid), 32'd0);
        chk("lock_lp", 32'(line_period), 32'(PERIOD_MIN));
        chk("lock_cs", 32'(csync_out), 32'd1);

        // Reset in the middle of a pulse, then recover.
        ev_rst_at = 300;
        line(200, 2000);
        chk("rst_lp", 32'(line_period), 32'd0);
        chk("rst_pv", 32'(period_valid), 32'd0);
        line($urandom_range(8, 700), PERIOD_MIN);
        line(200, 600);
        chk("rec_lp", 32'(line_period), 32'(PERIOD_MIN));
        chk("rec_pv", 32'(period_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
